// File: rtl/task_stream_arbiter.sv
// Round-robin packet arbiter feeding a task deserializer: grants one whole
// first/last-delimited packet at a time and waits for the deserializer's completion.
module task_stream_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int MAX_BEATS    = 3072,
  parameter int DONE_TIMEOUT = 4096,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ-1:0]    i_req_first,
  input  logic [NUM_REQ-1:0]    i_req_last,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_first,
  output logic                  o_last,
  input  logic                  i_des_done,
  output logic [ID_W-1:0]       o_grant_id,
  output logic                  o_busy,
  output logic                  o_gap_err,
  output logic                  o_trunc,
  output logic                  o_timeout,
  output logic [15:0]           o_drop_cnt
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int TMO_W  = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic [ID_W-1:0]       win_q, win_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [15:0]           drop_q, drop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  gap_q, gap_d;
  logic                  trunc_q, trunc_d;
  logic                  tmo_q, tmo_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    stray;
  logic [ID_W:0]         stray_cnt;
  logic [16:0]           drop_sum;
  logic                  win_found;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W-1:0]       cand;
  logic [BEAT_W-1:0]     beat_next;
  logic                  at_limit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign eligible[gi] = i_req_valid[gi] & i_req_first[gi];
    assign stray[gi]    = i_req_valid[gi] & ~i_req_first[gi];
  end

  // Rotating search: first eligible requester at or after the rr pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    stray_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      stray_cnt = stray_cnt + (ID_W + 1)'(stray[k]);
    end
  end

  assign drop_sum  = {1'b0, drop_q} + 17'(stray_cnt);
  assign beat_next = beat_q + BEAT_W'(1);
  assign at_limit  = (beat_next == BEAT_W'(MAX_BEATS));

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    beat_d      = beat_q;
    tmo_cnt_d   = tmo_cnt_q;
    drop_d      = drop_q;
    data_d      = '0;
    valid_d     = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    gap_d       = 1'b0;
    trunc_d     = 1'b0;
    tmo_d       = 1'b0;
    o_req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // Stray mid-packet beats are swallowed so they cannot stall a source.
        o_req_ready = stray;
        if (stray_cnt != '0) drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (win_found) begin
          o_req_ready[win_idx] = 1'b1;
          win_d   = win_idx;
          valid_d = 1'b1;
          first_d = 1'b1;
          data_d  = i_req_data[win_idx];
          beat_d  = beat_next;
          if (i_req_last[win_idx]) begin
            last_d  = 1'b1;
            state_d = ST_DRAIN;
          end else if (at_limit) begin
            last_d  = 1'b1;
            trunc_d = 1'b1;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        o_req_ready[win_q] = 1'b1;
        if (i_req_valid[win_q]) begin
          valid_d = 1'b1;
          data_d  = i_req_data[win_q];
          beat_d  = beat_next;
          if (i_req_last[win_q]) begin
            last_d  = 1'b1;
            state_d = ST_DRAIN;
          end else if (at_limit) begin
            last_d  = 1'b1;
            trunc_d = 1'b1;
            state_d = ST_FLUSH;
          end
        end else begin
          gap_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        o_req_ready[win_q] = 1'b1;
        if (i_req_valid[win_q] && i_req_last[win_q]) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // Completion wins over a simultaneous timeout.
        if (i_des_done || tmo_cnt_q == TMO_W'(DONE_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          rr_d      = (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + ID_W'(1);
          beat_d    = '0;
          tmo_cnt_d = '0;
          tmo_d     = ~i_des_done;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      win_q     <= '0;
      beat_q    <= '0;
      tmo_cnt_q <= '0;
      drop_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      gap_q     <= 1'b0;
      trunc_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      beat_q    <= beat_d;
      tmo_cnt_q <= tmo_cnt_d;
      drop_q    <= drop_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      trunc_q   <= trunc_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_first    = first_q;
  assign o_last     = last_q;
  assign o_grant_id = win_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_gap_err  = gap_q;
  assign o_trunc    = trunc_q;
  assign o_timeout  = tmo_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_task_stream_arbiter.sv
// Packet-level randomized bench for task_stream_arbiter: sources hold pending
// packets, the bench predicts winners round-robin and each forwarded/flushed beat.
module tb_task_stream_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 8;
  localparam int DT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] req_data [NR];
  logic [NR-1:0] req_valid, req_first, req_last, req_ready;
  logic [DW-1:0] o_data;
  logic          o_valid, o_first, o_last, des_done;
  logic [1:0]    grant;
  logic          busy, gap_err, trunc, tmo;
  logic [15:0]   drop;

  int errors = 0;
  int checks = 0;

  // Reference state: pending packet per source, rr pointer, stray count.
  bit            pend [NR];
  int            plen [NR];
  logic [7:0]    pdat [NR][16];
  int            rr;
  int            drop_m;
  int            owner;
  int            pkt_no;

  task_stream_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BEATS(MB), .DONE_TIMEOUT(DT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_data(req_data), .i_req_valid(req_valid),
    .i_req_first(req_first), .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_data(o_data), .o_valid(o_valid), .o_first(o_first), .o_last(o_last),
    .i_des_done(des_done), .o_grant_id(grant), .o_busy(busy),
    .o_gap_err(gap_err), .o_trunc(trunc), .o_timeout(tmo), .o_drop_cnt(drop)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (pkt %0d): got %h expected %h", tag, pkt_no, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic b, input logic to, input logic t, input logic g,
                                     input logic v, input logic f, input logic l, input logic [7:0] d);
    return {17'b0, b, to, t, g, v, f, l, d};
  endfunction

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic f,
                           input logic l, input logic g, input logic t, input logic to, input logic b);
    check_eq(tag, pk(busy, tmo, trunc, gap_err, o_valid, o_first, o_last, o_data),
             pk(b, to, t, g, v, f, l, d));
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NR; i++) req_data[i] = '0;
    req_valid = '0; req_first = '0; req_last = '0;
  endtask

  // Every pending source other than the owner offers its first beat.
  task automatic present();
    clear_inputs();
    for (int i = 0; i < NR; i++) begin
      if (pend[i] && i != owner) begin
        req_valid[i] = 1'b1;
        req_first[i] = 1'b1;
        req_last[i]  = (plen[i] == 1);
        req_data[i]  = pdat[i][0];
      end
    end
  endtask

  task automatic tick(input logic [3:0] exp_ready);
    #1;
    check_eq("ready", {28'b0, req_ready}, {28'b0, exp_ready});
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < pct) begin
        pend[i] = 1'b1;
        plen[i] = $urandom_range(1, 12);
        for (int j = 0; j < 16; j++) pdat[i][j] = 8'($urandom);
      end
    end
  endtask

  task automatic idle_cycle();
    logic [3:0] strays;
    strays = 4'($urandom_range(0, 15));
    clear_inputs();
    for (int i = 0; i < NR; i++) begin
      if (strays[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = 1'($urandom);
        req_data[i]  = 8'($urandom);
      end
    end
    des_done = 1'($urandom);
    tick(strays);
    drop_m += $countones(strays);
    check_out("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("drop_idle", {16'b0, drop}, 32'(drop_m));
    $display("pkt %0d: idle cycle, strays=%b drop=%0d", pkt_no, strays, drop_m);
    pkt_no++;
  endtask

  // One full transaction: arbitration, body (with gaps / truncation), drain.
  task automatic run_packet(input int gap_pct, input int done_delay);
    int w, n, dd;
    logic [3:0] strays;
    logic [3:0] onehot;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (rr + k) % NR;
      if (w < 0 && pend[idx]) w = idx;
    end
    owner = -1;
    present();
    strays = '0;
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && $urandom_range(0, 3) == 0) begin
        strays[i] = 1'b1;
        req_valid[i] = 1'b1;
        req_first[i] = 1'b0;
        req_last[i]  = 1'($urandom);
        req_data[i]  = 8'($urandom);
      end
    end
    onehot = 4'(1 << w);
    des_done = ($urandom_range(0, 7) == 0);
    tick(strays | onehot);
    drop_m += $countones(strays);
    n = plen[w];
    pend[w] = 1'b0;
    owner = w;
    check_out("first_beat", 1, pdat[w][0], 1, (n == 1), 0, 0, 0, 1);
    check_eq("grant", {30'b0, grant}, 32'(w));
    check_eq("drop", {16'b0, drop}, 32'(drop_m));

    for (int j = 2; j <= n; j++) begin
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
        present();
        des_done = ($urandom_range(0, 7) == 0);
        tick(onehot);
        if (j <= MB) check_out("gap", 0, 0, 0, 0, 1, 0, 0, 1);
        else         check_out("flush_gap", 0, 0, 0, 0, 0, 0, 0, 1);
      end
      present();
      req_valid[w] = 1'b1;
      req_first[w] = 1'b0;
      req_last[w]  = (j == n);
      req_data[w]  = pdat[w][j-1];
      des_done = ($urandom_range(0, 7) == 0);
      tick(onehot);
      if (j <= MB) check_out("beat", 1, pdat[w][j-1], 0, (j == n || j == MB), 0,
                             (j == MB && j != n), 0, 1);
      else         check_out("flush", 0, 0, 0, 0, 0, 0, 0, 1);
    end

    dd = (done_delay < 0) ? $urandom_range(0, 19) : done_delay;
    present();
    for (int k = 1; k <= DT; k++) begin
      des_done = (k == dd + 1);
      tick(4'b0);
      if (k == dd + 1) begin
        check_out("done", 0, 0, 0, 0, 0, 0, 0, 0);
        break;
      end else if (k == DT) begin
        check_out("timeout", 0, 0, 0, 0, 0, 0, 1, 0);
      end else begin
        check_out("drain", 0, 0, 0, 0, 0, 0, 0, 1);
      end
    end
    des_done = 1'b0;
    rr = (w + 1) % NR;
    owner = -1;
    $display("pkt %0d: src=%0d len=%0d strays=%b done_delay=%0d %s", pkt_no, w, n, strays, dd,
             (dd + 1 > DT) ? "timeout" : "done");
    pkt_no++;
  endtask

  initial begin
    rr = 0; drop_m = 0; owner = -1; pkt_no = 0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      plen[i] = 0;
    end
    rst = 1'b1;
    des_done = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("reset_grant", {30'b0, grant}, 32'd0);
    check_eq("reset_drop", {16'b0, drop}, 32'd0);
    rst = 1'b0;

    // Six-beat packet from source 0, completion five cycles after the last beat.
    pend[0] = 1'b1;
    plen[0] = 6;
    for (int j = 0; j < 16; j++) pdat[0][j] = 8'(8'h10 + j);
    run_packet(0, 4);

    // All sources with one-beat packets: pure rotation.
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      plen[i] = 1;
      for (int j = 0; j < 16; j++) pdat[i][j] = 8'($urandom);
    end
    repeat (NR) run_packet(0, -1);

    // Long packet truncated at the beat limit, then abandoned by timeout.
    pend[1] = 1'b1;
    plen[1] = 11;
    for (int j = 0; j < 16; j++) pdat[1][j] = 8'($urandom);
    run_packet(40, 100);

    for (int it = 0; it < 80; it++) begin
      refill(50);
      if (pend[0] || pend[1] || pend[2] || pend[3]) run_packet(30, -1);
      else idle_cycle();
    end

    // Reset in the middle of a packet.
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    pend[3] = 1'b1;
    plen[3] = 10;
    for (int j = 0; j < 16; j++) pdat[3][j] = 8'($urandom);
    owner = -1;
    present();
    tick(4'b1000);
    if (rr == 3) check_eq("pre_rst_grant", {30'b0, grant}, 32'd3);
    owner = 3;
    present();
    req_valid[3] = 1'b1;
    req_data[3]  = pdat[3][1];
    tick(4'b1000);
    check_out("pre_rst_beat", 1, pdat[3][1], 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_mid_grant", {30'b0, grant}, 32'd0);
    check_eq("rst_mid_drop", {16'b0, drop}, 32'd0);
    rst = 1'b0;
    rr = 0; drop_m = 0; owner = -1;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    clear_inputs();
    tick(4'b0);
    check_out("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);

    // Pointer back at 0: source 0 must win again.
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      plen[i] = $urandom_range(1, 4);
      for (int j = 0; j < 16; j++) pdat[i][j] = 8'($urandom);
    end
    repeat (NR) run_packet(20, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
